// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS core: walks each instruction through
// FETCH/EXEC, drives the instruction-memory request and selects the next PC.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    input  logic        eret,
    input  logic        halt,
    input  logic        if_ack,
    output logic        if_req,
    output logic [31:0] if_addr,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        instr_valid,
    output logic [1:0]  exc_cause,
    output logic        halted
);

    // state   | meaning
    // S_IDLE  | one settling cycle after reset
    // S_FETCH | if_req high, waiting for if_ack
    // S_EXEC  | instruction at pc executing, next pc chosen here
    // S_HALT  | core stopped until reset
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t      state;
    logic [31:0] target;
    logic        check_align;
    logic        misaligned;

    // Redirect sources are checked for alignment; pc + 4 stays aligned by construction.
    always_comb begin
        target      = pc + 32'd4;
        check_align = 1'b0;
        if (eret) begin
            target      = epc;
            check_align = 1'b1;
        end else if (jump) begin
            target      = jump_target;
            check_align = 1'b1;
        end else if (br_taken) begin
            target      = br_target;
            check_align = 1'b1;
        end
    end

    assign misaligned = check_align && (target[1:0] != 2'b00);
    assign if_addr    = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            epc         <= 32'd0;
            exc_cause   <= 2'd0;
            if_req      <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state  <= S_FETCH;
                    if_req <= 1'b1;
                end
                S_FETCH: begin
                    if (if_ack) begin
                        state       <= S_EXEC;
                        if_req      <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // exc outranks stall; a misaligned redirect only matters once the instruction retires
                    if (exc || (!stall && !halt && misaligned)) begin
                        epc         <= pc;
                        pc          <= EXC_VECTOR;
                        exc_cause   <= exc ? 2'd1 : 2'd2;
                        state       <= S_FETCH;
                        if_req      <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (stall) begin
                        state <= S_EXEC;
                    end else if (halt) begin
                        state       <= S_HALT;
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        pc          <= target;
                        state       <= S_FETCH;
                        if_req      <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver predicts each next fetch from
// a transaction-level model, a monitor checks it when the DUT raises if_req.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] VEC    = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, exc = 1'b0, eret = 1'b0, halt = 1'b0;
    logic        if_ack = 1'b0;
    logic [31:0] br_target = 32'd0, jump_target = 32'd0;
    logic        if_req, instr_valid, halted;
    logic [31:0] if_addr, pc, epc;
    logic [1:0]  exc_cause;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target), .exc(exc), .eret(eret), .halt(halt),
        .if_ack(if_ack), .if_req(if_req), .if_addr(if_addr), .pc(pc), .epc(epc),
        .instr_valid(instr_valid), .exc_cause(exc_cause), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        exc, stall, halt, eret, jump, br;
        logic [31:0] jt, bt;
    } ctl_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        logic [1:0]  cause;
        bit          is_halt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    bit          m_halted;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic ctl_t mk(input bit e, input bit s, input bit h, input bit r, input bit j,
                                input bit b, input logic [31:0] jt, input logic [31:0] bt);
        ctl_t c;
        c.exc = e; c.stall = s; c.halt = h; c.eret = r; c.jump = j; c.br = b;
        c.jt = jt; c.bt = bt;
        return c;
    endfunction

    // Architectural effect of retiring one instruction with controls c.
    function automatic void model_retire(input ctl_t c);
        logic [31:0] t;
        bit          redirect;
        redirect = 1'b1;
        if (c.exc) begin
            m_epc = m_pc; m_pc = VEC; m_cause = 2'd1;
            return;
        end
        if (c.halt) begin
            m_halted = 1'b1;
            return;
        end
        if (c.eret)      t = m_epc;
        else if (c.jump) t = c.jt;
        else if (c.br)   t = c.bt;
        else begin
            t = m_pc + 32'd4;
            redirect = 1'b0;
        end
        if (redirect && (t % 4 != 0)) begin
            m_epc = m_pc; m_pc = VEC; m_cause = 2'd2;
        end else begin
            m_pc = t;
        end
    endfunction

    // Monitor: pop an expectation each time the DUT starts a fetch or halts.
    logic [31:0] cur_addr = RST_PC;
    bit          req_prev = 1'b0, halt_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if ((if_req && !req_prev) || (halted && !halt_prev)) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: if_req=%0b halted=%0b pc=%h, nothing expected", if_req, halted, pc);
                end else begin
                    e = q.pop_front();
                    chk("event_is_halt", {31'd0, halted}, {31'd0, e.is_halt});
                    chk(e.is_halt ? "halt_pc" : "fetch_addr", e.is_halt ? pc : if_addr, e.addr);
                    chk("epc", epc, e.epc);
                    chk("exc_cause", {30'd0, exc_cause}, {30'd0, e.cause});
                    cur_addr = e.addr;
                end
            end
            if (instr_valid) chk("exec_pc", pc, cur_addr);
            req_prev  = if_req;
            halt_prev = halted;
        end
    end

    task automatic clear_ctl();
        stall = 0; exc = 0; halt = 0; eret = 0; jump = 0; br_taken = 0;
    endtask

    task automatic do_reset(input bit late_ack);
        rst = 1'b1;
        @(negedge clk);
        chk("pending_at_reset", q.size(), 0);
        q.delete();
        chk("rst_if_req", {31'd0, if_req}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_epc", epc, 32'd0);
        chk("rst_valid_halted", {30'd0, instr_valid, halted}, 32'd0);
        m_pc = RST_PC; m_epc = 32'd0; m_cause = 2'd0; m_halted = 1'b0;
        q.push_back('{RST_PC, 32'd0, 2'd0, 1'b0});
        rst    = 1'b0;
        if_ack = late_ack;
        @(negedge clk);
        if_ack = 1'b0;
        chk("idle_to_fetch_req", {31'd0, if_req}, 32'd1);
        chk("idle_ack_ignored", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic run_instr(input int ack_dly, input int stall_cyc, input ctl_t c);
        int n = 0;
        while (!if_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_req) begin
            checks++; errors++;
            $display("FAIL req_timeout: if_req=0 after %0d cycles, required 1", n);
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            chk("fetch_wait_req", {31'd0, if_req}, 32'd1);
            @(negedge clk);
        end
        chk("fetch_ack_req", {31'd0, if_req}, 32'd1);
        if_ack = 1'b1;
        @(negedge clk);
        if_ack = 1'b0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_no_req", {31'd0, if_req}, 32'd0);
        for (int i = 0; i < stall_cyc; i++) begin
            stall = 1; exc = 0;
            halt = 1'($urandom); eret = 1'($urandom); jump = 1'($urandom); br_taken = 1'($urandom);
            jump_target = $urandom; br_target = $urandom;
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = c.stall; exc = c.exc; halt = c.halt; eret = c.eret;
        jump = c.jump; br_taken = c.br; jump_target = c.jt; br_target = c.bt;
        model_retire(c);
        q.push_back('{m_pc, m_epc, m_cause, m_halted});
        @(negedge clk);
        clear_ctl();
    endtask

    task automatic halt_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if_ack = 1'($urandom);
            @(negedge clk);
            chk("halt_no_req", {31'd0, if_req}, 32'd0);
            chk("halt_flag", {31'd0, halted}, 32'd1);
        end
        if_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    ctl_t none;
    initial begin
        ctl_t  c;
        logic [31:0] jt, bt;
        none = mk(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);

        do_reset(1'b0);
        run_instr(0, 0, none);                                               // 3000 -> 3004
        run_instr(3, 2, none);                                               // 3004 -> 3008
        run_instr(0, 0, mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));                 // exc + stall
        run_instr(0, 0, mk(0, 0, 0, 1, 0, 0, 32'd0, 32'd0));                 // eret -> 3008
        run_instr(0, 0, mk(0, 0, 0, 0, 1, 1, 32'h3100, 32'h3200));           // jump wins
        run_instr(1, 0, mk(0, 0, 0, 0, 0, 1, 32'd0, 32'h3202));              // misaligned branch
        run_instr(0, 0, mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'd0));
        run_instr(0, 0, none);                                               // wrap to 0
        run_instr(0, 0, mk(0, 0, 1, 0, 0, 0, 32'd0, 32'd0));
        halt_hold(10);

        do_reset(1'b0);
        run_instr(0, 0, none);
        rst = 1'b1;                                                          // reset mid-FETCH
        @(negedge clk);
        chk("midfetch_req_drop", {31'd0, if_req}, 32'd0);
        chk("midfetch_pc", pc, RST_PC);
        q.delete();
        do_reset(1'b1);

        for (int k = 0; k < 300; k++) begin
            jt = ($urandom_range(0, 4) == 0) ? $urandom : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bt = ($urandom_range(0, 4) == 0) ? $urandom : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            c = mk($urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, jt, bt);
            if (c.exc) c.stall = 1'($urandom);
            run_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, c);
            if (m_halted) begin
                halt_hold(3);
                do_reset($urandom_range(0, 1) == 1);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
